// File: rtl/vlc_bit_packer_if.sv
// Stream interface for vlc_bit_packer: variable-length code input and packed word output.
// The master side produces codes and consumes words; the slave side is the packer.
interface vlc_bit_packer_if #(
    parameter int OUT_W   = 32,
    parameter int MAX_LEN = 32
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int NB_W  = $clog2(OUT_W + 1);

    logic               in_valid;
    logic               in_ready;
    logic [MAX_LEN-1:0] in_data;
    logic [LEN_W-1:0]   in_len;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic [NB_W-1:0]    out_nbits;
    logic               out_last;

    modport master (
        output in_valid, in_data, in_len, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_nbits, out_last
    );

    modport slave (
        input  in_valid, in_data, in_len, in_last, out_ready,
        output in_ready, out_valid, out_data, out_nbits, out_last
    );
endinterface

// File: rtl/vlc_bit_packer.sv
// Variable-length code packer: FIFO of right-aligned codes, packed MSB-first into OUT_W words.
// Optional macro VLC_PACK_STATS_EN compiles in a 32-bit counter of packed code bits.
module vlc_bit_packer #(
    parameter int OUT_W   = 32,
    parameter int MAX_LEN = 32,
    parameter int DEPTH   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    vlc_bit_packer_if.slave            s,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [31:0]                bit_count
);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int NB_W   = $clog2(OUT_W + 1);
    localparam int ACC_W  = OUT_W + MAX_LEN;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int AW     = $clog2(DEPTH);
    localparam int ENT_W  = 1 + LEN_W + MAX_LEN;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_r, state_nx_s;
    logic [ENT_W-1:0]   mem_r [DEPTH];
    logic [AW:0]        wr_ptr_r, rd_ptr_r;
    logic [ACC_W-1:0]   acc_r;
    logic [FILL_W-1:0]  fill_r;
    logic               pending_last_r;

    logic               full_s, empty_s, push_s, pop_s, out_hs_s;
    logic [LEN_W-1:0]   len_sat_s;
    logic [MAX_LEN-1:0] data_mask_s;
    logic [ENT_W-1:0]   pop_entry_s;
    logic               pop_last_s;
    logic [LEN_W-1:0]   pop_len_s;
    logic [MAX_LEN-1:0] pop_data_s;
    logic [FILL_W-1:0]  fill_add_s, shamt_s;
    logic [ACC_W-1:0]   append_s;

    assign full_s     = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign s.in_ready = rst && !full_s;
    assign push_s     = s.in_valid && s.in_ready;
    assign pop_s      = (state_r == ST_FILL) && !empty_s;
    assign out_hs_s   = s.out_valid && s.out_ready;
    assign fifo_count = wr_ptr_r - rd_ptr_r;

    // Saturate the length and strip data bits above it before they enter the FIFO.
    always_comb begin
        len_sat_s   = (s.in_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : s.in_len;
        data_mask_s = s.in_data & ~({MAX_LEN{1'b1}} << len_sat_s);
    end

    // FIFO storage is deliberately left unreset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {s.in_last, len_sat_s, data_mask_s};
        end
    end

    // Place the popped code directly below the current fill, MSB-first.
    always_comb begin
        pop_entry_s = mem_r[rd_ptr_r[AW-1:0]];
        pop_last_s  = pop_entry_s[ENT_W-1];
        pop_len_s   = pop_entry_s[MAX_LEN +: LEN_W];
        pop_data_s  = pop_entry_s[MAX_LEN-1:0];
        fill_add_s  = fill_r + FILL_W'(pop_len_s);
        shamt_s     = FILL_W'(ACC_W) - fill_r - FILL_W'(pop_len_s);
        append_s    = {{OUT_W{1'b0}}, pop_data_s} << shamt_s;
    end

    // FIFO pointers with an extra wrap bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            if (pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) state_r <= ST_FILL;
        else      state_r <= state_nx_s;
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (!pop_s)                               state_nx_s = ST_FILL;
                else if (fill_add_s >= FILL_W'(OUT_W))    state_nx_s = ST_EMIT;
                else if (pop_last_s)                      state_nx_s = ST_FLUSH;
                else                                      state_nx_s = ST_FILL;
            end
            ST_EMIT: begin
                if (!out_hs_s)                                         state_nx_s = ST_EMIT;
                else if (pending_last_r && (fill_r != FILL_W'(OUT_W))) state_nx_s = ST_FLUSH;
                else                                                   state_nx_s = ST_FILL;
            end
            ST_FLUSH: begin
                if (out_hs_s) state_nx_s = ST_FILL;
                else          state_nx_s = ST_FLUSH;
            end
            default: state_nx_s = ST_FILL;
        endcase
    end

    // Output decode; everything is driven from registers so it holds under backpressure.
    always_comb begin
        s.out_valid = 1'b0;
        s.out_data  = {OUT_W{1'b0}};
        s.out_nbits = {NB_W{1'b0}};
        s.out_last  = 1'b0;
        case (state_r)
            ST_EMIT: begin
                s.out_valid = rst;
                s.out_data  = acc_r[ACC_W-1 -: OUT_W];
                s.out_nbits = NB_W'(OUT_W);
                s.out_last  = pending_last_r && (fill_r == FILL_W'(OUT_W));
            end
            ST_FLUSH: begin
                s.out_valid = rst;
                s.out_data  = acc_r[ACC_W-1 -: OUT_W];
                s.out_nbits = fill_r[NB_W-1:0];
                s.out_last  = 1'b1;
            end
            default: begin
                s.out_valid = 1'b0;
            end
        endcase
    end

    // Accumulator, fill level and the deferred end-of-stream flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_r          <= {ACC_W{1'b0}};
            fill_r         <= {FILL_W{1'b0}};
            pending_last_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (pop_s) begin
                        acc_r  <= acc_r | append_s;
                        fill_r <= fill_add_s;
                        if (fill_add_s >= FILL_W'(OUT_W)) pending_last_r <= pop_last_s;
                    end
                end
                ST_EMIT: begin
                    if (out_hs_s) begin
                        acc_r  <= acc_r << OUT_W;
                        fill_r <= fill_r - FILL_W'(OUT_W);
                        if (fill_r == FILL_W'(OUT_W)) pending_last_r <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (out_hs_s) begin
                        acc_r          <= {ACC_W{1'b0}};
                        fill_r         <= {FILL_W{1'b0}};
                        pending_last_r <= 1'b0;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

`ifdef VLC_PACK_STATS_EN
    logic [31:0] bit_cnt_r;

    // Running total of effective code bits taken from the FIFO.
    always_ff @(posedge clk) begin
        if (!rst)       bit_cnt_r <= 32'd0;
        else if (pop_s) bit_cnt_r <= bit_cnt_r + 32'(pop_len_s);
    end

    assign bit_count = bit_cnt_r;
`else
    assign bit_count = 32'd0;
`endif
endmodule

// File: doc/vlc_bit_packer.md
VLC_BIT_PACKER -- requirements
Module: vlc_bit_packer

Interface
REQ-001 SHALL have parameter OUT_W, default 32: packed output word width in bits.
REQ-002 SHALL have parameter MAX_LEN, default 32: maximum code length; constraint 1 <= MAX_LEN <= OUT_W.
REQ-003 SHALL have parameter DEPTH, default 64: input FIFO entries; power of two >= 2.
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- in_valid  in  1  code present.
- in_ready  out  1  FIFO can accept.
- in_data  in  MAX_LEN  code, right-aligned.
- in_len  in  $clog2(MAX_LEN+1)  valid code bits.
- in_last  in  1  final code of stream.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts.
- out_data  out  OUT_W  packed word, MSB-first.
- out_nbits  out  $clog2(OUT_W+1)  valid bits in out_data.
- out_last  out  1  final word of stream.
- fifo_count  out  $clog2(DEPTH+1)  FIFO occupancy.
- bit_count  out  32  statistics counter (REQ-024).

Function
REQ-006 SHALL push {in_last, in_len, in_data} into a circular FIFO when in_valid && in_ready; in_ready = !full.
REQ-007 FIFO pointers SHALL carry one extra wrap bit. Full = indices equal and wrap bits differ. Empty = pointers equal.
REQ-008 SHALL make an entry written at edge t available for pop no earlier than edge t+1; no write-through.
REQ-009 SHALL saturate in_len > MAX_LEN to MAX_LEN, and SHALL ignore in_data bits at or above the effective length.
REQ-010 SHALL hold an accumulator of OUT_W+MAX_LEN bits and a fill counter, 0..OUT_W+MAX_LEN-1; codes append MSB-first directly below the current fill.
REQ-011 State FILL: when FIFO non-empty, SHALL pop one entry per cycle, append it, and fill += len. Next state:
- new fill >= OUT_W -> EMIT; the entry's last bit is latched into pending_last.
- else last && new fill > 0 -> FLUSH.
- else last && new fill == 0 -> FLUSH, emitting an empty word.
- else stay in FILL.
REQ-012 State EMIT: out_valid=1, out_data = accumulator top OUT_W bits, out_nbits=OUT_W, out_last = pending_last && fill==OUT_W.
REQ-013 On an EMIT handshake, SHALL shift the accumulator left OUT_W and fill -= OUT_W. Next state:
- remaining fill > 0 && pending_last -> FLUSH.
- fill==0 && pending_last -> FILL, with pending_last cleared.
- otherwise -> FILL.
REQ-014 State FLUSH: out_valid=1, out_data = top bits zero-padded, out_nbits=fill, out_last=1. On handshake: acc=0, fill=0, pending_last=0, -> FILL.
REQ-015 SHALL not pop the FIFO in EMIT or FLUSH; codes after in_last wait until FLUSH completes.
REQ-016 out_data, out_nbits and out_last SHALL stay stable while out_valid && !out_ready.
REQ-017 Sustained throughput: one code per cycle in FILL; each output word costs one EMIT cycle plus backpressure.
REQ-018 fifo_count SHALL equal write pointer minus read pointer, DEPTH when full; it updates on the edge after a push or pop.

Reset
REQ-019 With rst==0 at a rising edge, SHALL clear: FIFO pointers, accumulator, fill, pending_last, bit_count; state -> FILL.
REQ-020 While rst==0, in_ready=0 and out_valid=0. After reset: out_data=0, out_nbits=0, out_last=0, fifo_count=0.
REQ-021 Reset mid-stream SHALL discard FIFO contents and any partial word; nothing is emitted.
REQ-022 FIFO storage array SHALL not be reset.

Configuration
REQ-023 Macro VLC_PACK_STATS_EN SHALL compile in a bit counter.
REQ-024 Defined: bit_count accumulates effective in_len of every popped code, wraps modulo 2^32, and clears on reset. Undefined: bit_count is tied to 0 and no counter logic exists.

Verification
REQ-025 Len 8 codes A1,B2,C3,D4, last on D4 -> one word 32'hA1B2C3D4, nbits=32, out_last=1.
REQ-026 Single code len 3 = 3'b101, last -> 32'hA0000000, nbits=3, out_last=1.
REQ-027 Len 20 0xABCDE, then len 20 0x12345 with last -> 32'hABCDE123 nbits=32 last=0, then 32'h45000000 nbits=8 last=1.
REQ-028 in_len=40, in_data=32'hFFFFFFFF, last -> treated as 32 bits: 32'hFFFFFFFF nbits=32 last=1. Len 4, in_data=32'hDEADBEE5, last -> 32'h50000000 nbits=4.
REQ-029 out_ready=0, 100 len-32 pushes -> in_ready falls once fifo_count=64. Release -> all words in order, no loss or duplication.
REQ-030 rst=0 mid-stream with 10 entries queued -> out_valid=0 next cycle, fifo_count=0. Len 0 last code at fill 0 -> one word, nbits=0, out_last=1. With VLC_PACK_STATS_EN, REQ-027 ends with bit_count=40.
